// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index, data word and pipeline-controller state encoding.
// No logic; consumed by the pipeline control path.
// Backpressure: n/a.
package cpu_types_pkg;

    typedef logic [4:0]  regbits_t;
    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        PC_RUN,
        PC_DWAIT,
        PC_HALT
    } pctrl_state_t;

endpackage

// File: rtl/pipe_hazard_detect.sv
// Load-use detector: flags an ID instruction that sources the register an EX load is writing.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; the controller decides what to do with the flag.
module pipe_hazard_detect
    import cpu_types_pkg::*;
(
    input  logic     dREN_ex,
    input  regbits_t regDst_ex,
    input  regbits_t rs_id,
    input  regbits_t rt_id,
    input  logic     usert_id,
    output logic     loaduse
);

    // $0 is hardwired zero, so a load targeting it can never create a dependency.
    assign loaduse = dREN_ex && (regDst_ex != '0) &&
                     ((regDst_ex == rs_id) || (usert_id && (regDst_ex == rt_id)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller: latch enables/flushes for load-use, branch squash, cache waits, halt.
// Latency: outputs combinational from state+inputs, applied at the same cycle's latch edge.
// Backpressure: dcache miss freezes every latch; icache miss bubbles ID. PIPE_PERF_EN adds perf counters.
module pipeline_ctrl
    import cpu_types_pkg::*;
#(
    parameter int MAX_WAIT = 255
`ifdef PIPE_PERF_EN
    ,
    parameter int CNT_W    = 32
`endif
)
(
    input  logic     CLK,
    input  logic     RST,
    input  logic     ihit,
    input  logic     dhit,
    input  regbits_t rs_id,
    input  regbits_t rt_id,
    input  logic     usert_id,
    input  logic     dREN_ex,
    input  regbits_t regDst_ex,
    input  logic     jmp_ex,
    input  logic     dREN_mem,
    input  logic     dWEN_mem,
    input  logic     halt_mem,
    output logic     pcen,
    output logic     ifen,
    output logic     flush_id,
    output logic     exen,
    output logic     flush_ex,
    output logic     memen,
    output logic     flush_mem,
    output logic     wben,
    output logic     halt,
    output logic     timeout
`ifdef PIPE_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] squash_cnt
`endif
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    pctrl_state_t      state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              timeout_q, timeout_d;
    logic              loaduse;
    logic              dstall;

    pipe_hazard_detect u_hazard (
        .dREN_ex   (dREN_ex),
        .regDst_ex (regDst_ex),
        .rs_id     (rs_id),
        .rt_id     (rt_id),
        .usert_id  (usert_id),
        .loaduse   (loaduse)
    );

    assign dstall  = (dREN_mem || dWEN_mem) && !dhit;
    assign halt    = (state_q == PC_HALT) && !RST;
    assign timeout = timeout_q && !RST;

    // Next-state and latch controls, resolved in strict priority order.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        pcen       = 1'b1;
        ifen       = 1'b1;
        exen       = 1'b1;
        memen      = 1'b1;
        wben       = 1'b1;
        flush_id   = 1'b0;
        flush_ex   = 1'b0;
        flush_mem  = 1'b0;

        if (RST) begin
            // Hold every latch and keep clearing them until reset drops.
            {pcen, ifen, exen, memen, wben} = '0;
            {flush_id, flush_ex, flush_mem} = '1;
        end else if (state_q == PC_HALT) begin
            {pcen, ifen, exen, memen, wben} = '0;
        end else if (dstall) begin
            // Freeze the whole pipe; count only cycles already spent waiting.
            {pcen, ifen, exen, memen, wben} = '0;
            state_d = PC_DWAIT;
            if (state_q == PC_DWAIT && wait_cnt_q != WAIT_MAX) begin
                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
            timeout_d = timeout_q || (wait_cnt_d == WAIT_MAX);
        end else begin
            state_d    = PC_RUN;
            wait_cnt_d = '0;
            if (halt_mem) begin
                // Let the halt retire into WB, drain everything younger.
                pcen      = 1'b0;
                flush_id  = 1'b1;
                flush_ex  = 1'b1;
                flush_mem = 1'b1;
                state_d   = PC_HALT;
            end else if (jmp_ex) begin
                // Redirect wins: ID and EX hold wrong-path work, so stalls there are moot.
                flush_id = 1'b1;
                flush_ex = 1'b1;
            end else if (loaduse) begin
                // Single bubble; the load reaches MEM next cycle where forwarding covers it.
                pcen     = 1'b0;
                ifen     = 1'b0;
                flush_ex = 1'b1;
            end else if (!ihit) begin
                pcen     = 1'b0;
                flush_id = 1'b1;
            end
        end
    end

    // State, dmem wait counter and sticky timeout flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= PC_RUN;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

`ifdef PIPE_PERF_EN
    // Wrapping perf counters: PC-hold cycles while running, and squashing redirects.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt  <= '0;
            squash_cnt <= '0;
        end else begin
            if (!pcen && !halt) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (jmp_ex && !dstall && !halt) begin
                squash_cnt <= squash_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: driver queues expected controls per cycle, monitor checks at negedge.
// Latency: expectations apply to the same cycle the inputs are driven.
// Backpressure: n/a; perf counters are checked only when PIPE_PERF_EN is defined.
module tb_pipeline_ctrl;
    import cpu_types_pkg::*;

    logic     CLK = 1'b0;
    logic     RST, ihit, dhit, usert_id, dREN_ex, jmp_ex, dREN_mem, dWEN_mem, halt_mem;
    regbits_t rs_id, rt_id, regDst_ex;
    logic     pcen, ifen, flush_id, exen, flush_ex, memen, flush_mem, wben, halt, timeout;
`ifdef PIPE_PERF_EN
    logic [31:0] stall_cnt, squash_cnt;
`endif

    pipeline_ctrl #(.MAX_WAIT(4)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .rs_id(rs_id), .rt_id(rt_id), .usert_id(usert_id),
        .dREN_ex(dREN_ex), .regDst_ex(regDst_ex), .jmp_ex(jmp_ex),
        .dREN_mem(dREN_mem), .dWEN_mem(dWEN_mem), .halt_mem(halt_mem),
        .pcen(pcen), .ifen(ifen), .flush_id(flush_id), .exen(exen),
        .flush_ex(flush_ex), .memen(memen), .flush_mem(flush_mem),
        .wben(wben), .halt(halt), .timeout(timeout)
`ifdef PIPE_PERF_EN
        , .stall_cnt(stall_cnt), .squash_cnt(squash_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    // Output vector: {pcen,ifen,flush_id,exen,flush_ex,memen,flush_mem,wben,halt,timeout}
    logic [9:0] outv;
    assign outv = {pcen, ifen, flush_id, exen, flush_ex, memen, flush_mem, wben, halt, timeout};

    localparam logic [9:0] ALL     = 10'h3FF;
    localparam logic [9:0] V_RST   = 10'b0010101000;
    localparam logic [9:0] V_RUN   = 10'b1101010100;
    localparam logic [9:0] V_RUNTO = 10'b1101010101;
    localparam logic [9:0] V_FRZ   = 10'b0000000000;
    localparam logic [9:0] V_FRZTO = 10'b0000000001;
    localparam logic [9:0] V_HALTD = 10'b0000000010;
    localparam logic [9:0] V_LU    = 10'b0001110100;
    localparam logic [9:0] M_LU    = 10'b1110111111;
    localparam logic [9:0] V_JMP   = 10'b1111110100;
    localparam logic [9:0] M_JMP   = 10'b1010111111;
    localparam logic [9:0] V_IMISS = 10'b0111010100;
    localparam logic [9:0] V_HMEM  = 10'b0111111100;
    localparam logic [9:0] M_HMEM  = 10'b1010101111;

    typedef struct {
        string       nm;
        logic [9:0]  v;
        logic [9:0]  m;
        logic        perf;
        logic [31:0] sc;
        logic [31:0] qc;
    } exp_t;

    exp_t sbq[$];
    int checks = 0;
    int errors = 0;

    task automatic push(input string nm, input logic [9:0] v, input logic [9:0] m,
                        input logic perf, input logic [31:0] sc, input logic [31:0] qc);
        exp_t e;
        e.nm = nm; e.v = v; e.m = m; e.perf = perf; e.sc = sc; e.qc = qc;
        sbq.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    task automatic step(input string nm, input logic [9:0] v, input logic [9:0] m);
        push(nm, v, m, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic quiet();
        RST = 1'b0; ihit = 1'b1; dhit = 1'b0; usert_id = 1'b0; dREN_ex = 1'b0;
        jmp_ex = 1'b0; dREN_mem = 1'b0; dWEN_mem = 1'b0; halt_mem = 1'b0;
        rs_id = 5'd0; rt_id = 5'd0; regDst_ex = 5'd0;
    endtask

    task automatic set_lu(input regbits_t r);
        dREN_ex = 1'b1; regDst_ex = r; rs_id = r;
    endtask

    // Monitor: compare the DUT against the oldest queued expectation each negedge.
    always @(negedge CLK) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++;
            if ((outv & e.m) !== (e.v & e.m)) begin
                errors++;
                $display("FAIL %s: got %b want %b (mask %b)", e.nm, outv, e.v, e.m);
            end
`ifdef PIPE_PERF_EN
            if (e.perf) begin
                checks++;
                if (stall_cnt !== e.sc || squash_cnt !== e.qc) begin
                    errors++;
                    $display("FAIL %s_perf: got stall=%0d squash=%0d want stall=%0d squash=%0d",
                             e.nm, stall_cnt, squash_cnt, e.sc, e.qc);
                end
            end
`endif
        end
    end

    initial begin
        quiet();
        RST = 1'b1;
        @(posedge CLK);
        #1;
        // Reset
        quiet(); RST = 1'b1;                 step("rst", V_RST, ALL);
        quiet();                             step("idle", V_RUN, ALL);
        // T1 load-use
        quiet(); set_lu(5'd2);               step("lu_rs", V_LU, M_LU);
        quiet(); rs_id = 5'd2;               step("lu_after", V_RUN, ALL);
        quiet(); set_lu(5'd0);               step("lu_r0", V_RUN, ALL);
        quiet(); dREN_ex = 1'b1; regDst_ex = 5'd7; rs_id = 5'd3; rt_id = 5'd7; usert_id = 1'b1;
                                             step("lu_rt", V_LU, M_LU);
        quiet(); dREN_ex = 1'b1; regDst_ex = 5'd7; rs_id = 5'd3; rt_id = 5'd7;
                                             step("lu_rt_unused", V_RUN, ALL);
        // T2 redirect beats load-use and icache miss
        quiet(); set_lu(5'd2); jmp_ex = 1'b1; ihit = 1'b0;
                                             step("jmp_lu", V_JMP, M_JMP);
        quiet(); ihit = 1'b0;                step("imiss", V_IMISS, ALL);
        quiet(); ihit = 1'b0; set_lu(5'd4);  step("imiss_lu", V_LU, ALL & ~10'b0001000000);
        // T3 dcache wait, resolved before timeout
        quiet(); dREN_mem = 1'b1;            step("dw0", V_FRZ, ALL);
        quiet(); dREN_mem = 1'b1;            step("dw1", V_FRZ, ALL);
        quiet(); dREN_mem = 1'b1;            step("dw2", V_FRZ, ALL);
        quiet(); dREN_mem = 1'b1; dhit = 1'b1; step("dw_hit", V_RUN, ALL);
        quiet(); dWEN_mem = 1'b1;            step("st_wait", V_FRZ, ALL);
        quiet(); dWEN_mem = 1'b1; dhit = 1'b1; step("st_hit", V_RUN, ALL);
        // T4 timeout after MAX_WAIT=4 DWAIT cycles, sticky until reset
        for (int i = 0; i < 5; i++) begin
            quiet(); dREN_mem = 1'b1;        step($sformatf("to_wait%0d", i), V_FRZ, ALL);
        end
        quiet(); dREN_mem = 1'b1;            step("to_fire", V_FRZTO, ALL);
        quiet(); dREN_mem = 1'b1;            step("to_sat", V_FRZTO, ALL);
        quiet(); dREN_mem = 1'b1; dhit = 1'b1; step("to_sticky", V_RUNTO, ALL);
        quiet(); RST = 1'b1;                 step("to_rst", V_RST, ALL);
        quiet();                             step("to_cleared", V_RUN, ALL);
        // T5 halt
        quiet(); halt_mem = 1'b1;            step("halt_mem", V_HMEM, M_HMEM);
        quiet();                             step("halted", V_HALTD, ALL);
        quiet(); jmp_ex = 1'b1; dREN_mem = 1'b1; set_lu(5'd9);
                                             step("halted_busy", V_HALTD, ALL);
        quiet(); RST = 1'b1;                 step("halt_rst", V_RST, ALL);
        // T6 perf counters start from the reset above
        quiet();                             push("pf0", V_RUN, ALL, 1'b1, 32'd0, 32'd0);
        quiet(); set_lu(5'd5);               push("pf_lu1", V_LU, M_LU, 1'b1, 32'd0, 32'd0);
        quiet();                             push("pf1", V_RUN, ALL, 1'b1, 32'd1, 32'd0);
        quiet(); set_lu(5'd6);               push("pf_lu2", V_LU, M_LU, 1'b1, 32'd1, 32'd0);
        quiet(); jmp_ex = 1'b1;              push("pf_jmp", V_JMP, M_JMP, 1'b1, 32'd2, 32'd0);
        quiet();                             push("pf_end", V_RUN, ALL, 1'b1, 32'd2, 32'd1);
        // Drain: monitor must consume every queued expectation within a bounded wait.
        for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge CLK);
        if (sbq.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
